// File: rtl/calc_controller.sv
// Keypad calculator controller: collects operands and operator keys,
// drives the arithmetic datapath and picks the value to display.
module calc_controller #(
   parameter int          MAX_DIGITS = 6,
   parameter logic [31:0] ERR_CODE   = 32'h00EE0000,
   parameter int          WAIT_CYC   = 2
) (
   input  logic        sw_clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [4:0]  key_code,
   input  logic [31:0] calc_result,
   output logic [31:0] operand1,
   output logic [31:0] operand2,
   output logic [2:0]  operator,
   output logic        calc_strobe,
   output logic [31:0] disp_value,
   output logic        busy,
   output logic        err
);

   localparam int DW = $clog2(MAX_DIGITS + 1);
   localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

   typedef enum logic [2:0] {
      S_A,
      S_B,
      S_EXEC,
      S_WAIT,
      S_SHOW,
      S_ERR
   } state_t;

   state_t        st, st_n;
   logic          pend, pend_n;
   logic [2:0]    pend_op, pend_op_n;
   logic [DW-1:0] dig1, dig1_n;
   logic [DW-1:0] dig2, dig2_n;
   logic [CW-1:0] wcnt, wcnt_n;

   logic [31:0]   op1_n, op2_n, disp_n;
   logic [2:0]    opr_n;
   logic          strobe_n;

   logic          is_dig, is_op, is_eq, is_clr, is_neg;
   logic [2:0]    key_op;
   logic [3:0]    key_dig;
   logic          div0;

   // Magnitude-based append so negative operands grow away from zero.
   function automatic logic [31:0] push_digit(
      input logic [31:0] v,
      input logic [3:0]  d
   );
      logic [31:0] mag;
      logic [31:0] m;
      mag = v[31] ? -v : v;
      m   = mag * 32'd10 + {28'd0, d};
      return v[31] ? -m : m;
   endfunction

   always_comb begin
      is_dig  = key_valid && (key_code <= 5'd9);
      is_op   = key_valid && (key_code >= 5'd10) && (key_code <= 5'd14);
      is_eq   = key_valid && (key_code == 5'd15);
      is_clr  = key_valid && (key_code == 5'd16);
      is_neg  = key_valid && (key_code == 5'd17);
      key_op  = key_code[2:0] - 3'd2;
      key_dig = key_code[3:0];
      div0    = ((operator == 3'd3) || (operator == 3'd4))
                && (operand2 == 32'd0);
   end

   always_comb begin
      st_n      = st;
      op1_n     = operand1;
      op2_n     = operand2;
      opr_n     = operator;
      pend_n    = pend;
      pend_op_n = pend_op;
      dig1_n    = dig1;
      dig2_n    = dig2;
      wcnt_n    = wcnt;
      strobe_n  = 1'b0;

      if (is_clr && st != S_EXEC && st != S_WAIT) begin
         st_n   = S_A;
         op1_n  = 32'd0;
         op2_n  = 32'd0;
         opr_n  = 3'd0;
         pend_n = 1'b0;
         dig1_n = '0;
         dig2_n = '0;
      end else begin
         unique case (st)
            S_A: begin
               if (is_dig && dig1 < DW'(MAX_DIGITS)) begin
                  op1_n  = push_digit(operand1, key_dig);
                  dig1_n = dig1 + 1'b1;
               end else if (is_neg) begin
                  op1_n = -operand1;
               end else if (is_op) begin
                  opr_n  = key_op;
                  op2_n  = 32'd0;
                  dig2_n = '0;
                  st_n   = S_B;
               end
            end
            S_B: begin
               if (is_dig && dig2 < DW'(MAX_DIGITS)) begin
                  op2_n  = push_digit(operand2, key_dig);
                  dig2_n = dig2 + 1'b1;
               end else if (is_neg) begin
                  op2_n = -operand2;
               end else if ((is_op || is_eq) && dig2 != '0) begin
                  // The operator that ends operand2 runs next, after this one.
                  pend_n    = is_op;
                  pend_op_n = key_op;
                  if (div0) begin
                     st_n   = S_ERR;
                     pend_n = 1'b0;
                  end else begin
                     st_n     = S_EXEC;
                     strobe_n = 1'b1;
                  end
               end else if (is_op) begin
                  opr_n = key_op;
               end
            end
            S_EXEC: begin
               st_n   = S_WAIT;
               wcnt_n = '0;
            end
            S_WAIT: begin
               if (wcnt == CW'(WAIT_CYC - 1)) begin
                  if (calc_result == ERR_CODE) begin
                     st_n   = S_ERR;
                     pend_n = 1'b0;
                  end else begin
                     op1_n  = calc_result;
                     dig1_n = '0;
                     if (pend) begin
                        opr_n  = pend_op;
                        op2_n  = 32'd0;
                        dig2_n = '0;
                        pend_n = 1'b0;
                        st_n   = S_B;
                     end else begin
                        st_n = S_SHOW;
                     end
                  end
               end else begin
                  wcnt_n = wcnt + 1'b1;
               end
            end
            S_SHOW: begin
               if (is_dig) begin
                  op1_n  = {28'd0, key_dig};
                  dig1_n = DW'(1);
                  st_n   = S_A;
               end else if (is_op) begin
                  opr_n  = key_op;
                  op2_n  = 32'd0;
                  dig2_n = '0;
                  st_n   = S_B;
               end
            end
            S_ERR: ;
            default: st_n = S_A;
         endcase
      end
   end

   always_comb begin
      unique case (st_n)
         S_A, S_SHOW: disp_n = op1_n;
         S_B:         disp_n = op2_n;
         S_ERR:       disp_n = ERR_CODE;
         default:     disp_n = disp_value;
      endcase
   end

   always_ff @(posedge sw_clk or negedge rst) begin
      if (!rst) begin
         st          <= S_A;
         operand1    <= 32'd0;
         operand2    <= 32'd0;
         operator    <= 3'd0;
         pend        <= 1'b0;
         pend_op     <= 3'd0;
         dig1        <= '0;
         dig2        <= '0;
         wcnt        <= '0;
         calc_strobe <= 1'b0;
         disp_value  <= 32'd0;
         busy        <= 1'b0;
         err         <= 1'b0;
      end else begin
         st          <= st_n;
         operand1    <= op1_n;
         operand2    <= op2_n;
         operator    <= opr_n;
         pend        <= pend_n;
         pend_op     <= pend_op_n;
         dig1        <= dig1_n;
         dig2        <= dig2_n;
         wcnt        <= wcnt_n;
         calc_strobe <= strobe_n;
         disp_value  <= disp_n;
         busy        <= (st_n == S_EXEC) || (st_n == S_WAIT);
         err         <= (st_n == S_ERR);
      end
   end

endmodule
